mat_deskew: RTL and testbench

- Output-side counterpart of the matmul skew buffers.
- Takes diagonally skewed result columns leaving the bottom edge of the systolic array, and realigns them by delaying column j by DIM-1-j enabled cycles.
- Packs each aligned row into a 2-entry output queue, drained by writeback over valid/ready.
- Back-pressures the array through `stall`.

---
 rtl/mat_pkg.sv | 17 +
 rtl/mat_delay_line.sv | 40 ++++
 rtl/mat_deskew.sv | 155 +++++++++++++++
 tb/tb_mat_deskew.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the matmul output deskew path: default sizes,
// the queue entry layout and the per-column delay depth.
package mat_pkg;

  localparam int MAT_DIM_DEF  = 8;
  localparam int MAT_BITS_DEF = 64;

  typedef struct packed {
    logic [MAT_DIM_DEF*MAT_BITS_DEF-1:0] data;
    logic [$clog2(MAT_DIM_DEF)-1:0]      row;
  } mat_entry_t;

  function automatic int delay_of(input int j, input int dim);
    return dim - 1 - j;
  endfunction

endpackage

// File: rtl/mat_delay_line.sv
// Enable-gated shift chain of DEPTH stages; DEPTH=0 degenerates to a wire.
module mat_delay_line #(
  parameter int DEPTH = 1,
  parameter int BITS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic lint_unused_s;
      assign lint_unused_s = ^{clk, rst, clr, en};
      assign q = d;
    end else begin : g_chain
      logic [BITS-1:0] stage_q [DEPTH];

      // shift register advancing only on enabled cycles
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en) begin
          stage_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end else begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_q[i];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mat_deskew.sv
// Realigns diagonally skewed systolic-array result columns into rows and
// queues them (2 deep) for writeback, back-pressuring the array via stall.
module mat_deskew
  import mat_pkg::*;
#(
  parameter int DIM   = MAT_DIM_DEF,
  parameter int BITS  = MAT_BITS_DEF,
  parameter int ROW_W = $clog2(DIM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_en,
  input  logic [DIM-1:0]      in_valid,
  input  logic [DIM*BITS-1:0] in_data,
  output logic                stall,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIM*BITS-1:0] out_data,
  output logic [ROW_W-1:0]    out_row,
  output logic                out_last,
  output logic                align_err,
  output logic                ovf_err
);

  typedef struct packed {
    logic [DIM*BITS-1:0] data;
    logic [ROW_W-1:0]    row;
  } entry_t;

  logic [DIM-1:0]      av_s;
  logic [DIM*BITS-1:0] ad_s;

  for (genvar j = 0; j < DIM; j++) begin : g_col
    logic [BITS:0] q_s;
    mat_delay_line #(
      .DEPTH(delay_of(j, DIM)),
      .BITS (BITS + 1)
    ) u_dl (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en (in_en),
      .d  ({in_valid[j], in_data[j*BITS +: BITS]}),
      .q  (q_s)
    );
    assign av_s[j]               = q_s[BITS];
    assign ad_s[j*BITS +: BITS]  = q_s[BITS-1:0];
  end

  entry_t           head_q, head_d, tail_q, tail_d, new_s;
  logic [1:0]       count_q, count_d;
  logic [ROW_W-1:0] row_q, row_d, row_inc_s;
  logic             align_err_q, align_err_d, ovf_err_q, ovf_err_d;
  logic             strobe_s, partial_s, pop_s;

  assign new_s     = {ad_s, row_q};
  assign pop_s     = (count_q != 2'd0) && out_ready;
  assign row_inc_s = (row_q == ROW_W'(DIM - 1)) ? '0 : row_q + ROW_W'(1);

  // alignment is only judged on cycles where the array actually shifted
  always_comb begin
    strobe_s  = 1'b0;
    partial_s = 1'b0;
    if (in_en) begin
      strobe_s  = &av_s;
      partial_s = (|av_s) && !(&av_s);
    end else begin
      strobe_s  = 1'b0;
      partial_s = 1'b0;
    end
  end

  // queue, row counter and sticky error next-state
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    row_d       = row_q;
    align_err_d = align_err_q;
    ovf_err_d   = ovf_err_q;
    if (clr) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = 2'd0;
      row_d       = '0;
      align_err_d = 1'b0;
      ovf_err_d   = 1'b0;
    end else begin
      if (partial_s) align_err_d = 1'b1;
      else           align_err_d = align_err_q;
      case ({strobe_s, pop_s})
        2'b10: begin
          case (count_q)
            2'd0: begin
              head_d  = new_s;
              count_d = 2'd1;
              row_d   = row_inc_s;
            end
            2'd1: begin
              tail_d  = new_s;
              count_d = 2'd2;
              row_d   = row_inc_s;
            end
            default: ovf_err_d = 1'b1;
          endcase
        end
        2'b01: begin
          if (count_q == 2'd2) head_d = tail_q;
          else                 head_d = head_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // simultaneous push/pop keeps the count; the new row lands behind any remaining entry
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = new_s;
          end else begin
            head_d = new_s;
          end
          row_d = row_inc_s;
        end
        default: count_d = count_q;
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      row_q       <= '0;
      align_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      row_q       <= row_d;
      align_err_q <= align_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign stall     = (count_q == 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q.data;
  assign out_row   = head_q.row;
  assign out_last  = (head_q.row == ROW_W'(DIM - 1));
  assign align_err = align_err_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_mat_deskew.sv
// Directed bench for mat_deskew at DIM=4, BITS=16.
module tb_mat_deskew;

  localparam int DIM   = 4;
  localparam int BITS  = 16;
  localparam int ROW_W = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr = 1'b0;
  logic                in_en = 1'b0;
  logic                out_ready = 1'b0;
  logic [DIM-1:0]      in_valid = '0;
  logic [DIM*BITS-1:0] in_data = '0;
  logic                stall, out_valid, out_last, align_err, ovf_err;
  logic [DIM*BITS-1:0] out_data;
  logic [ROW_W-1:0]    out_row;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mat_deskew #(.DIM(DIM), .BITS(BITS), .ROW_W(ROW_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_en    (in_en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .stall    (stall),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_last (out_last),
    .align_err(align_err),
    .ovf_err  (ovf_err)
  );

  function automatic logic [DIM*BITS-1:0] row_val(input int r);
    logic [DIM*BITS-1:0] v;
    v = '0;
    for (int c = 0; c < DIM; c++) v[c*BITS +: BITS] = 16'(r*16 + c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // present skew slot k of a tile: column j carries row k-j
  task automatic slot(input int k);
    in_valid = '0;
    in_data  = '0;
    for (int j = 0; j < DIM; j++) begin
      if (k - j >= 0 && k - j < DIM) begin
        in_valid[j]            = 1'b1;
        in_data[j*BITS +: BITS] = 16'((k - j)*16 + j);
      end
    end
  endtask

  task automatic idle_in;
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic chk_head(input string tag, input int r);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data),  64'(row_val(r)));
    chk({tag, "_row"},   64'(out_row),   64'(r));
    chk({tag, "_last"},  64'(out_last),  64'(r == DIM - 1));
  endtask

  task automatic do_clr;
    in_en = 1'b0;
    idle_in();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  logic [DIM-1:0] mis_mask [5];

  initial begin
    // reset state
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall),     64'd0);
    chk("rst_data",  64'(out_data),  64'd0);
    chk("rst_row",   64'(out_row),   64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_aerr",  64'(align_err), 64'd0);
    chk("rst_oerr",  64'(ovf_err),   64'd0);
    rst = 1'b0;

    // 1: single tile, free-flowing output
    in_en = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      slot(k);
      tick();
      if (k < 3) chk($sformatf("s1_early%0d", k), 64'(out_valid), 64'd0);
      else       chk_head($sformatf("s1_r%0d", k - 3), k - 3);
    end
    idle_in();
    tick();
    chk("s1_drain", 64'(out_valid), 64'd0);
    chk("s1_aerr",  64'(align_err), 64'd0);
    chk("s1_oerr",  64'(ovf_err),   64'd0);

    // 2: back-pressure, upstream honours stall
    do_clr();
    out_ready = 1'b0;
    in_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      slot(k);
      tick();
      if (k == 3) chk("s2_stall_r0", 64'(stall), 64'd0);
      if (k == 4) chk("s2_stall_r1", 64'(stall), 64'd1);
    end
    in_en = 1'b0;
    slot(5);
    repeat (3) tick();
    chk_head("s2_hold", 0);
    chk("s2_stall_hold", 64'(stall), 64'd1);
    out_ready = 1'b1;
    tick();
    chk_head("s2_pop", 1);
    chk("s2_stall_rel", 64'(stall), 64'd0);
    in_en = 1'b1;
    slot(5);
    tick();
    chk_head("s2_r2", 2);
    slot(6);
    tick();
    chk_head("s2_r3", 3);
    idle_in();
    tick();
    chk("s2_drain", 64'(out_valid), 64'd0);
    chk("s2_oerr",  64'(ovf_err),   64'd0);

    // 3: forced overflow, rows 2 and 3 dropped
    do_clr();
    out_ready = 1'b0;
    in_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      slot(k);
      tick();
      if (k == 4) chk("s3_oerr_pre",  64'(ovf_err), 64'd0);
      if (k == 5) chk("s3_oerr_set",  64'(ovf_err), 64'd1);
    end
    chk_head("s3_q0", 0);
    idle_in();
    in_en = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_head("s3_q1", 1);
    tick();
    chk("s3_empty", 64'(out_valid), 64'd0);
    chk("s3_oerr_sticky", 64'(ovf_err), 64'd1);

    // 4: column 2 one cycle late for row 0
    do_clr();
    mis_mask[0] = 4'b0001;
    mis_mask[1] = 4'b0010;
    mis_mask[2] = 4'b0000;
    mis_mask[3] = 4'b1100;
    mis_mask[4] = 4'b0000;
    out_ready = 1'b1;
    in_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = mis_mask[k];
      in_data  = '0;
      for (int j = 0; j < DIM; j++) in_data[j*BITS +: BITS] = 16'(j);
      tick();
      if (k == 2) chk("s4_aerr_pre", 64'(align_err), 64'd0);
      if (k >= 3) begin
        chk($sformatf("s4_aerr%0d", k),  64'(align_err), 64'd1);
        chk($sformatf("s4_nopush%0d", k), 64'(out_valid), 64'd0);
      end
    end
    chk("s4_oerr_clr", 64'(ovf_err), 64'd0);

    // 5: in_en gapped 1,0,1,0 with junk on disabled cycles
    do_clr();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_en = 1'b1;
      slot(k);
      tick();
      if (k < 3) chk($sformatf("s5_early%0d", k), 64'(out_valid), 64'd0);
      else       chk_head($sformatf("s5_r%0d", k - 3), k - 3);
      in_en = 1'b0;
      in_valid = '1;
      in_data  = {DIM{16'hDEAD}};
      tick();
      chk($sformatf("s5_gap%0d", k), 64'(out_valid), 64'd0);
    end
    chk("s5_aerr", 64'(align_err), 64'd0);
    chk("s5_oerr", 64'(ovf_err),   64'd0);

    // 6a: asynchronous reset mid-tile
    do_clr();
    out_ready = 1'b0;
    in_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      slot(k);
      tick();
    end
    chk_head("s6_pre", 0);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_valid", 64'(out_valid), 64'd0);
    chk("s6_rst_data",  64'(out_data),  64'd0);
    chk("s6_rst_row",   64'(out_row),   64'd0);
    chk("s6_rst_last",  64'(out_last),  64'd0);
    chk("s6_rst_stall", 64'(stall),     64'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      slot(k);
      tick();
      if (k < 3) chk($sformatf("s6_early%0d", k), 64'(out_valid), 64'd0);
      else       chk_head($sformatf("s6_r%0d", k - 3), k - 3);
    end

    // 6b: clr with one entry queued, a pop and a row strobe in the same cycle
    slot(5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s6_clr_valid", 64'(out_valid), 64'd0);
    chk("s6_clr_stall", 64'(stall),     64'd0);
    chk("s6_clr_row",   64'(out_row),   64'd0);
    for (int k = 0; k < 4; k++) begin
      slot(k);
      tick();
      if (k < 3) chk($sformatf("s6_new_early%0d", k), 64'(out_valid), 64'd0);
    end
    chk_head("s6_new_r0", 0);
    chk("s6_aerr", 64'(align_err), 64'd0);
    chk("s6_oerr", 64'(ovf_err),   64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
